// File: rtl/btb_ctrl.sv
// btb_ctrl: branch target buffer controller around an external dual-port RAM.
//   Port A is a read-only lookup port whose data returns one cycle later and
//   feeds the prediction outputs. Port B clears every entry after reset, then
//   serves read-modify-write updates. Each update takes a read cycle and a
//   compare/write cycle.
// Ports:
//   clk, rstn                              clock, async active-low reset
//   lkp_valid, lkp_pc                      lookup request
//   pred_valid/hit/taken/target            prediction, one cycle after lookup
//   upd_valid/ready/pc/taken/target        branch resolution update handshake
//   ram_ena/wea/addra/dina/douta           RAM port A (lookup reads)
//   ram_web/addrb/dinb/doutb               RAM port B (init clear, updates)
//   ram_rst                                RAM reset, tied low
// Entry layout: {valid[55], tag[54:32]=pc[31:9], target[31:2], ctr[1:0]}
// Build option: define BTB_BYPASS_EN to forward a port-B write to a lookup of
// the same index in the same cycle, because the RAM returns old data then.
module btb_ctrl #(
    parameter int unsigned IDX_W = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             lkp_valid,
    input  logic [31:0]      lkp_pc,
    output logic             pred_valid,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    output logic             ram_ena,
    output logic [6:0]       ram_wea,
    output logic [IDX_W-1:0] ram_addra,
    output logic [55:0]      ram_dina,
    input  logic [55:0]      ram_douta,
    output logic [6:0]       ram_web,
    output logic [IDX_W-1:0] ram_addrb,
    output logic [55:0]      ram_dinb,
    input  logic [55:0]      ram_doutb,
    output logic             ram_rst
);

    localparam int unsigned TAG_W = 23;
    localparam int unsigned TGT_W = 30;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CMP} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_upd_idx;
    logic [TAG_W-1:0]   r_upd_tag;
    logic               r_upd_taken;
    logic [TGT_W-1:0]   r_upd_target;
    logic               r_upd_ready;
    logic               r_pred_valid;
    logic [TAG_W-1:0]   r_lkp_tag;

    logic [IDX_W-1:0]   w_lkp_idx;
    logic [IDX_W-1:0]   w_upd_idx;
    logic               w_cmp_hit;
    logic [1:0]         w_ctr_old;
    logic [1:0]         w_ctr_new;
    logic [55:0]        w_rd_entry;
    logic               w_unused;

    assign w_lkp_idx = lkp_pc[IDX_W+1:2];
    assign w_upd_idx = upd_pc[IDX_W+1:2];

    // Port A is a permanent read port addressed by the live lookup pc
    assign ram_ena   = 1'b1;
    assign ram_wea   = 7'h00;
    assign ram_dina  = 56'h0;
    assign ram_addra = w_lkp_idx;
    assign ram_rst   = 1'b0;

    // Compare the entry read during the IDLE cycle against the latched update
    assign w_cmp_hit = ram_doutb[55] & (ram_doutb[54:32] == r_upd_tag);
    assign w_ctr_old = ram_doutb[1:0];

    // Saturating 2-bit direction counter
    always_comb begin
        w_ctr_new = w_ctr_old;
        if (r_upd_taken) begin
            if (w_ctr_old != 2'b11) w_ctr_new = w_ctr_old + 2'd1;
        end else begin
            if (w_ctr_old != 2'b00) w_ctr_new = w_ctr_old - 2'd1;
        end
    end

    // Port B drive: address must follow upd_pc in IDLE so the read lands in CMP
    always_comb begin
        ram_web   = 7'h00;
        ram_addrb = r_upd_idx;
        ram_dinb  = 56'h0;
        case (r_state)
            ST_INIT: begin
                ram_web   = 7'h7F;
                ram_addrb = r_cnt;
            end
            ST_IDLE: begin
                ram_addrb = w_upd_idx;
            end
            ST_CMP: begin
                if (w_cmp_hit) begin
                    ram_web  = 7'h7F;
                    ram_dinb = {1'b1, r_upd_tag, r_upd_target, w_ctr_new};
                end else if (r_upd_taken) begin
                    ram_web  = 7'h7F;
                    ram_dinb = {1'b1, r_upd_tag, r_upd_target, 2'b10};
                end
            end
            default: ;
        endcase
    end

    // Control FSM, update latches and lookup pipeline register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            r_upd_idx    <= '0;
            r_upd_tag    <= '0;
            r_upd_taken  <= 1'b0;
            r_upd_target <= '0;
            r_upd_ready  <= 1'b0;
            r_pred_valid <= 1'b0;
            r_lkp_tag    <= '0;
        end else begin
            r_pred_valid <= lkp_valid & (r_state != ST_INIT);
            r_lkp_tag    <= lkp_pc[31:9];
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + IDX_W'(1);
                    if (r_cnt == {IDX_W{1'b1}}) begin
                        r_state     <= ST_IDLE;
                        r_upd_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (upd_valid) begin
                        r_upd_idx    <= w_upd_idx;
                        r_upd_tag    <= upd_pc[31:9];
                        r_upd_taken  <= upd_taken;
                        r_upd_target <= upd_target[31:2];
                        r_upd_ready  <= 1'b0;
                        r_state      <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    r_state     <= ST_IDLE;
                    r_upd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_upd_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef BTB_BYPASS_EN
    logic        r_byp_valid;
    logic [55:0] r_byp_data;

    // Capture a port-B write that collides with this cycle's lookup read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_byp_valid <= 1'b0;
            r_byp_data  <= '0;
        end else begin
            r_byp_valid <= lkp_valid & (|ram_web) & (w_lkp_idx == ram_addrb);
            r_byp_data  <= ram_dinb;
        end
    end

    assign w_rd_entry = r_byp_valid ? r_byp_data : ram_douta;
`else
    assign w_rd_entry = ram_douta;
`endif

    assign pred_valid  = r_pred_valid;
    assign pred_hit    = r_pred_valid & w_rd_entry[55] & (w_rd_entry[54:32] == r_lkp_tag);
    assign pred_taken  = pred_hit & w_rd_entry[1];
    assign pred_target = pred_hit ? {w_rd_entry[31:2], 2'b00} : 32'h0;
    assign upd_ready   = r_upd_ready;

    assign w_unused = ^{ram_doutb[31:2], lkp_pc[1:0], upd_pc[1:0], upd_target[1:0]};

endmodule

// File: doc/btb_ctrl.md
BTB_CTRL -- requirements
Module: btb_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 7, meaning BTB index width; index = pc[IDX_W+1:2].
REQ-002 SHALL have port clk, input, 1, meaning sole clock; all flops on posedge.
REQ-003 SHALL have port rstn, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have lookup ports: lkp_valid in 1; lkp_pc in 32.
REQ-005 SHALL have prediction ports: pred_valid out 1; pred_hit out 1; pred_taken out 1; pred_target out 32.
REQ-006 SHALL have update ports: upd_valid in 1; upd_ready out 1; upd_pc in 32; upd_taken in 1; upd_target in 32.
REQ-007 SHALL have RAM port A: ram_ena out 1; ram_wea out 7; ram_addra out IDX_W; ram_dina out 56; ram_douta in 56.
REQ-008 SHALL have RAM port B: ram_web out 7; ram_addrb out IDX_W; ram_dinb out 56; ram_doutb in 56.
REQ-009 SHALL have ram_rst out 1, driven constant 0; RAM reads have 1-cycle latency.

Function
REQ-010 SHALL pack each 56-bit entry as {valid[55], tag[54:32]=pc[31:9], target[31:2] in [31:2], ctr[1:0]}.
REQ-011 SHALL hold ram_ena=1, ram_wea=0, ram_dina=0, and ram_addra=lkp_pc index every cycle.
REQ-012 SHALL register lkp_valid and the lookup tag; pred_* SHALL be valid the cycle after lkp_valid (latency 1).
REQ-013 SHALL assert pred_hit = pred_valid & entry.valid & (entry.tag == registered tag).
REQ-014 SHALL assert pred_taken = pred_hit & ctr[1]; pred_target = {entry.target, 2'b00} when pred_hit, else 0.
REQ-015 SHALL run FSM with states INIT, IDLE, CMP.
REQ-016 In INIT: write zero to entry cnt (ram_web=7'h7F, ram_addrb=cnt); cnt increments from 0 to 2^IDX_W-1; after the last entry go to IDLE; upd_ready=0; pred_valid forced 0.
REQ-017 In IDLE: upd_ready=1; on upd_valid, latch the upd_* fields, drive ram_addrb=upd index and ram_web=0 (read), and go to CMP.
REQ-018 In CMP: upd_ready=0; ram_addrb=latched index; on return to IDLE, the next update SHALL NOT be accepted in the same cycle (throughput one update per 2 cycles).
REQ-019 CMP hit (doutb valid & tag match): write with web=7'h7F; ctr saturating +1 (max 3) if taken, -1 (min 0) if not taken; target replaced with upd_target.
REQ-020 CMP miss & taken: allocate {1, tag, target, ctr=2'b10} with web=7'h7F.
REQ-021 CMP miss & not taken: no write (web=0).
REQ-022 Write-hazard case: a lookup index equal to the CMP write index in the same cycle, with a write occurring. The RAM returns the old data in this case.

Reset
REQ-023 rstn low SHALL force state=INIT, cnt=0, all latched fields=0, pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0, upd_ready=0.
REQ-024 Reset asserted mid-INIT or mid-CMP SHALL abandon the operation and restart the full INIT sweep.

Configuration
REQ-025 Macro BTB_BYPASS_EN defined: on the write hazard, the write data SHALL be registered and used in place of ram_douta for the next-cycle prediction.
REQ-026 Macro BTB_BYPASS_EN undefined: no forward path; the prediction SHALL use stale ram_douta.

Verification
REQ-027 Release reset -> upd_ready=0 for exactly 128 cycles, all 128 entries written 0, then upd_ready=1.
REQ-028 After init, lookup 0x0000_1004 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0.
REQ-029 Update pc=0x0000_1004 taken target=0x0000_2000, then lookup 0x0000_1004 -> pred_hit=1, pred_taken=1, pred_target=0x0000_2000.
REQ-030 Same pc, three not-taken updates -> ctr goes 2->1->0->0; lookup gives pred_hit=1, pred_taken=0.
REQ-031 Lookup 0x0000_1004 in the CMP write cycle of an allocate to 0x0000_1004 -> pred_hit=1 with BTB_BYPASS_EN, pred_hit=0 without it.
REQ-032 Alias test: update 0x0000_1004, then lookup 0x0000_3004 (same index, different tag) -> pred_hit=0; pull rstn low mid-CMP -> INIT restarts and the entry reads as a miss.
